// File: rtl/holy_lite_timer.sv
// Machine timer on the AXI-Lite peripheral bus: a 64-bit prescaled mtime,
// a 64-bit mtimecmp and a registered level interrupt.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW and W together; both accepted on the same edge
//   W_RESP | bvalid high, holding bresp until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high; AR accepted and read data captured on arvalid
//   R_DATA | rvalid high, rdata/rresp held stable until rready
module holy_lite_timer #(
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter logic [15:0] DIV_RST      = 16'd0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        timer_irq
);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   // Bits 15:1 of CTRL are reserved and always read back as zero.
   localparam logic [31:0] CTRL_MASK = 32'hFFFF_0001;

   w_state_t    w_state, w_next;
   r_state_t    r_state, r_next;
   logic        wr_fire, rd_fire;
   logic [2:0]  wr_sel, rd_sel;
   logic [63:0] mtime, mtimecmp;
   logic [31:0] mtime_hi_shadow;
   logic [31:0] ctrl_q;
   logic [15:0] presc_cnt;
   logic        tick;
   logic [31:0] rd_data_mux;
   logic [1:0]  rd_resp_mux;
   logic        addr_unused;

   assign addr_unused = ^{s_axi_awaddr[31:5], s_axi_awaddr[1:0],
                          s_axi_araddr[31:5], s_axi_araddr[1:0]};

   assign wr_sel = s_axi_awaddr[4:2];
   assign rd_sel = s_axi_araddr[4:2];
   assign tick   = ctrl_q[0] && (presc_cnt == ctrl_q[31:16]);

   function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

   // Write FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   // Write FSM next state and handshake outputs
   always_comb begin
      w_next        = w_state;
      wr_fire       = 1'b0;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            wr_fire       = s_axi_awvalid && s_axi_wvalid;
            s_axi_awready = wr_fire;
            s_axi_wready  = wr_fire;
            if (wr_fire) w_next = W_RESP;
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Read FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   // Read FSM next state and handshake outputs
   always_comb begin
      r_next        = r_state;
      rd_fire       = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            s_axi_arready = 1'b1;
            rd_fire       = s_axi_arvalid;
            if (s_axi_arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Write response code, captured on the AW/W handshake
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)     s_axi_bresp <= 2'b00;
      else if (wr_fire) s_axi_bresp <= (wr_sel[2:1] == 2'b11) ? 2'b10 : 2'b00;
   end

   // Read data mux; offsets 0x18/0x1C answer SLVERR with zero data
   always_comb begin
      rd_data_mux = 32'h0;
      rd_resp_mux = 2'b00;
      case (rd_sel)
         3'd0:    rd_data_mux = mtime[31:0];
         3'd1:    rd_data_mux = mtime_hi_shadow;
         3'd2:    rd_data_mux = mtimecmp[31:0];
         3'd3:    rd_data_mux = mtimecmp[63:32];
         3'd4:    rd_data_mux = ctrl_q;
         3'd5:    rd_data_mux = {31'h0, timer_irq};
         default: rd_resp_mux = 2'b10;
      endcase
   end

   // Read data capture, held stable while in R_DATA
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_axi_rdata <= 32'h0;
         s_axi_rresp <= 2'b00;
      end else if (rd_fire) begin
         s_axi_rdata <= rd_data_mux;
         s_axi_rresp <= rd_resp_mux;
      end
   end

   // Prescaler: counts 0..DIV while enabled, parked at 0 when disabled
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                        presc_cnt <= 16'd0;
      else if (!ctrl_q[0])                 presc_cnt <= 16'd0;
      else if (presc_cnt == ctrl_q[31:16]) presc_cnt <= 16'd0;
      else                                 presc_cnt <= presc_cnt + 16'd1;
   end

   // mtime: a bus write beats a tick for its half; the other half keeps its
   // pre-tick value with no carry
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         mtime <= 64'h0;
      else if (wr_fire && wr_sel == 3'd0)
         mtime <= {mtime[63:32], apply_strb(mtime[31:0], s_axi_wdata, s_axi_wstrb)};
      else if (wr_fire && wr_sel == 3'd1)
         mtime <= {apply_strb(mtime[63:32], s_axi_wdata, s_axi_wstrb), mtime[31:0]};
      else if (tick)
         mtime <= mtime + 64'd1;
   end

   // High-word shadow: snapshot on a MTIME_LO read, also loaded by MTIME_HI writes
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         mtime_hi_shadow <= 32'h0;
      else if (wr_fire && wr_sel == 3'd1)
         mtime_hi_shadow <= apply_strb(mtime[63:32], s_axi_wdata, s_axi_wstrb);
      else if (rd_fire && rd_sel == 3'd0)
         mtime_hi_shadow <= mtime[63:32];
   end

   // mtimecmp and CTRL byte-strobed writes
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mtimecmp <= MTIMECMP_RST;
         ctrl_q   <= {DIV_RST, 16'h0};
      end else if (wr_fire) begin
         case (wr_sel)
            3'd2: mtimecmp[31:0]  <= apply_strb(mtimecmp[31:0], s_axi_wdata, s_axi_wstrb);
            3'd3: mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], s_axi_wdata, s_axi_wstrb);
            3'd4: ctrl_q          <= apply_strb(ctrl_q, s_axi_wdata, s_axi_wstrb) & CTRL_MASK;
            default: ;
         endcase
      end
   end

   // Registered unsigned compare drives the level interrupt
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) timer_irq <= 1'b0;
      else          timer_irq <= (mtime >= mtimecmp);
   end

endmodule

// File: doc/holy_lite_timer.md
# holy_lite_timer

Memory-mapped machine timer on the core's AXI-Lite peripheral bus, downstream of the core's `m_axi_lite_*` master port. Keeps a 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register. It drives a level timer interrupt into one bit of the core's `irq_in`.

## Interface

Parameters:
- `MTIMECMP_RST`, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp`; the default means no interrupt after reset.
- `DIV_RST`, 16'd0, reset value of the prescaler divisor `CTRL[31:16]`.

Ports (one clock `aclk`; reset `aresetn` is asynchronous, active-low):
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_axi_awaddr` in 32: write address; only `[4:2]` is decoded, `[1:0]` is ignored.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata` in 32 / `s_axi_wstrb` in 4: write data and byte enables.
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1: write data handshake.
- `s_axi_bresp` out 2 / `s_axi_bvalid` out 1 / `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in 32: read address; only `[4:2]` is decoded.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1: read address handshake.
- `s_axi_rdata` out 32 / `s_axi_rresp` out 2 / `s_axi_rvalid` out 1 / `s_axi_rready` in 1: read data channel.
- `timer_irq` out 1: level interrupt, high while `mtime >= mtimecmp`.

## Operation

Register map (byte offsets):
- 0x00 `MTIME_LO`, RW.
- 0x04 `MTIME_HI`, RW. A read returns the shadow register (see Reads).
- 0x08 `MTIMECMP_LO`, RW.
- 0x0C `MTIMECMP_HI`, RW.
- 0x10 `CTRL`, RW. Bit 0 = `EN`; bits [31:16] = `DIV`; all other bits read 0.
- 0x14 `STATUS`, RO. Bit 0 = `timer_irq`. Writes are accepted with OKAY and have no effect.
- 0x18, 0x1C: unmapped. Response SLVERR (2'b10); writes are dropped; read data is 0.
- Write strobes apply per byte on every RW register.

Counting:
- While `EN`=1, the 16-bit prescaler count increments every cycle.
- When count == `DIV`: count is set to 0 and `mtime` increments by 1. `DIV`=0 therefore ticks every cycle.
- While `EN`=0, the prescaler count is held at 0 and `mtime` is frozen.
- `mtime` wraps from 2^64-1 to 0.
- If a bus write to `MTIME_LO` or `MTIME_HI` lands on a tick cycle, the write wins for the written half. The other half keeps its pre-tick value; no carry is applied.
- Compare is unsigned 64-bit. `timer_irq` is registered: it reflects `mtime >= mtimecmp` as evaluated on the previous cycle.

Reads:
- A read of `MTIME_LO` returns the live low word and, in the same cycle, latches the live `mtime[63:32]` into `mtime_hi_shadow`.
- A read of `MTIME_HI` returns `mtime_hi_shadow`. Software reads LO then HI to get a coherent 64-bit value.
- A write to `MTIME_HI` also updates the shadow.

Write FSM (`W_IDLE`, `W_RESP`):
- `W_IDLE`: `awready` = `wready` = (`awvalid` && `wvalid`), combinationally. When both are valid, the register is updated on that edge and the FSM goes to `W_RESP`.
- `W_RESP`: `bvalid`=1 and `bresp` holds its value; `awready` = `wready` = 0. The FSM returns to `W_IDLE` on `bready`.
- A lone `awvalid` or lone `wvalid` waits; neither is accepted alone.

Read FSM (`R_IDLE`, `R_DATA`):
- `R_IDLE`: `arready`=1. On `arvalid`, `rdata`/`rresp` are captured and the FSM goes to `R_DATA`.
- `R_DATA`: `arready`=0, `rvalid`=1, and data is held stable until `rready`, then the FSM returns to `R_IDLE`.
- The read and write FSMs run independently. If a read and a write to the same register complete on the same edge, the read returns the old value.

## Timing

- Reset values: `awready`=`wready`=0, `bvalid`=0, `bresp`=0, `arready`=1, `rvalid`=0, `rdata`=0, `rresp`=0, `timer_irq`=0. `mtime`=0, shadow=0, `mtimecmp`=`MTIMECMP_RST`, `CTRL`={`DIV_RST`,15'b0,1'b0}. Both FSMs reset to IDLE and the prescaler count to 0.
- Write latency: the register is updated on the AW/W handshake edge; `bvalid` rises on the next cycle.
- Read latency: `rvalid` rises on the cycle after the AR handshake. Maximum throughput is one read per 2 cycles.
- Interrupt latency: `timer_irq` changes 1 cycle after the `mtime` or `mtimecmp` edge that flips the compare.
- Reset asserted mid-transaction drops any pending response and returns all state to reset values immediately (asynchronously).

## Test plan

- Reset, then read 0x08 and 0x0C -> both return 0xFFFF_FFFF with OKAY; `timer_irq`=0; `arready`=1.
- Write `MTIMECMP_LO`=10, `MTIMECMP_HI`=0, then `CTRL`=0x0000_0001 -> `mtime` increments every cycle; `timer_irq` rises exactly 1 cycle after `mtime` reaches 10 and stays high.
- Write `CTRL`=0x0003_0001 -> `mtime` increments once every 4 cycles. Clear `EN` -> `mtime` freezes and the prescaler count is 0.
- Set `mtime`=0x0000_0000_FFFF_FFFF via two writes, enable with `DIV`=0, read LO then HI -> coherent pair (HI equals `mtime[63:32]` at the LO-read edge, including across the carry). Also write `mtime`=2^64-1 -> wraps to 0.
- Write with `wstrb`=4'b0010 and `wdata`=0xAAAA_BBCC to `MTIMECMP_LO` -> only byte 1 changes (to 0xBB). Assert `awvalid` alone for 5 cycles -> no `awready`, no `bvalid`.
- Access offset 0x18 (read and write) -> `rresp`/`bresp`=2'b10, `rdata`=0, no register changes. Hold `rready`=0 for 3 cycles -> `rvalid` and `rdata` stay stable. Assert reset mid-`W_RESP` -> `bvalid` drops to 0 immediately.
